instr_reg: RTL and testbench



---
 rtl/instr_reg_pkg.sv | 24 ++
 rtl/instr_reg.sv | 64 ++++++
 tb/tb_instr_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/instr_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_reg_pkg
// Purpose: Shared IAAA processor datapath constants. The register-write
//          decoder and every register it selects import the same select
//          indices from here, so the two sides cannot drift apart.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package instr_reg_pkg;

  // Datapath widths
  localparam int WR_WIDTH   = 20;  // write-decoder select vector
  localparam int DATA_WIDTH = 16;  // MIDR data bus
  localparam int IR_WIDTH   = 4;   // stored opcode

  // Register-select indices on the write-decoder bus
  localparam int IR_SEL     = 19;  // instruction register

  // Opcode field position within the instruction word
  localparam int OPC_LSB    = 0;

endpackage : instr_reg_pkg
`default_nettype wire

// File: rtl/instr_reg.sv
`default_nettype none
// ============================================================================
// Module : instr_reg
// Purpose: Instruction register. Captures the opcode field of the MIDR bus
//          when the write decoder selects the IR and holds it for the
//          control unit. Purely registered output, no input-to-output path.
// Ports  : Clock     in   1           system clock, rising edge
//          Reset     in   1           synchronous active-high reset
//          WRDec_out in   WR_WIDTH    write-decoder vector, bit WR_SEL used
//          MIDR_out  in   DATA_WIDTH  instruction word
//          IR_out    out  IR_WIDTH    registered opcode
// Rev    : 1.0 - initial release
// ============================================================================
module instr_reg
  import instr_reg_pkg::*;
#(
  parameter int WR_WIDTH   = instr_reg_pkg::WR_WIDTH,
  parameter int DATA_WIDTH = instr_reg_pkg::DATA_WIDTH,
  parameter int IR_WIDTH   = instr_reg_pkg::IR_WIDTH,
  parameter int WR_SEL     = instr_reg_pkg::IR_SEL,
  parameter int OPC_LSB    = instr_reg_pkg::OPC_LSB
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [WR_WIDTH-1:0]   WRDec_out,
  input  logic [DATA_WIDTH-1:0] MIDR_out,
  output logic [IR_WIDTH-1:0]   IR_out
);

  // Reject parameter sets that would index outside either bus.
  generate
    if (WR_SEL < 0 || WR_SEL >= WR_WIDTH) begin : g_bad_wr_sel
      $error("instr_reg: WR_SEL must lie within WRDec_out");
    end
    if (OPC_LSB < 0 || OPC_LSB + IR_WIDTH > DATA_WIDTH) begin : g_bad_opc_field
      $error("instr_reg: opcode field must lie within MIDR_out");
    end
  endgenerate

  logic                wr_en;
  logic [IR_WIDTH-1:0] opcode;
  logic [IR_WIDTH-1:0] ir_q;

  assign wr_en  = WRDec_out[WR_SEL];
  assign opcode = MIDR_out[OPC_LSB +: IR_WIDTH];

  // Reset has priority over a write on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q <= '0;
    end else if (wr_en) begin
      ir_q <= opcode;
    end
  end

  assign IR_out = ir_q;

  // Only one decoder bit and the opcode field are consumed; the remaining
  // bus bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, WRDec_out, MIDR_out};

endmodule : instr_reg
`default_nettype wire

// File: tb/tb_instr_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_reg
// Purpose: Directed self-checking bench for instr_reg.
// Ports  : none
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instr_reg;

  logic        Clock;
  logic        Reset;
  logic [19:0] WRDec_out;
  logic [15:0] MIDR_out;
  logic [3:0]  IR_out;

  int total = 0;
  int bad   = 0;

  instr_reg dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .WRDec_out (WRDec_out),
    .MIDR_out  (MIDR_out),
    .IR_out    (IR_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset     = 1'b1;
    WRDec_out = 20'h00000;
    MIDR_out  = 16'h5555;
    step();
    check("reset", IR_out, 4'b0000);

    Reset = 1'b0;
    step();
    check("no_select", IR_out, 4'b0000);

    WRDec_out = 20'h80000;
    step();
    check("load_5555", IR_out, 4'b0101);

    WRDec_out = 20'hFFFFF;
    MIDR_out  = 16'h0000;
    step();
    check("all_ones_load", IR_out, 4'b0000);

    WRDec_out = 20'h00000;
    MIDR_out  = 16'h5555;
    step();
    check("hold_zero", IR_out, 4'b0000);

    WRDec_out = 20'h80000;
    MIDR_out  = 16'h0009;
    step();
    check("load_9", IR_out, 4'b1001);

    WRDec_out = 20'h7FFFF;
    MIDR_out  = 16'hFFFF;
    step();
    check("other_bits_ignored", IR_out, 4'b1001);

    WRDec_out = 20'h80000;
    MIDR_out  = 16'hABC7;
    step();
    check("upper_bits_ignored", IR_out, 4'b0111);

    // A mid-cycle input change must not reach the output before the edge.
    MIDR_out = 16'h000C;
    #1;
    check("no_bypass", IR_out, 4'b0111);
    step();
    check("load_C", IR_out, 4'b1100);

    MIDR_out = 16'h000A;
    step();
    check("load_A", IR_out, 4'b1010);

    Reset    = 1'b1;
    MIDR_out = 16'h000F;
    step();
    check("reset_wins", IR_out, 4'b0000);

    Reset = 1'b0;
    step();
    check("load_F_after_reset", IR_out, 4'b1111);

    WRDec_out = 20'h00000;
    MIDR_out  = 16'h0000;
    step();
    step();
    check("hold_F", IR_out, 4'b1111);

    Reset = 1'b1;
    step();
    check("reset_clears", IR_out, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_reg
`default_nettype wire
